fifo_rd_port: RTL and testbench
===============================

FIFO_RD_PORT -- requirements
Module: fifo_rd_port

Interface
REQ-001 Parameter DATASIZE, default 8: memory data word width.
REQ-002 Parameter ADDRSIZE, default 4: memory address bits; depth = 2**ADDRSIZE.
REQ-003 One clock and an asynchronous, active-high reset: ports rclk and rrst.
REQ-004 rclk  input  1: read-domain clock; all state updates on its rising edge.
REQ-005 rrst  input  1: asynchronous, active-high reset.
REQ-006 rq2_wptr  input  ADDRSIZE+1: Gray write pointer, already two-flop synchronized into rclk.
REQ-007 rdata  input  DATASIZE: combinational memory read data for raddr.
REQ-008 raddr  output  ADDRSIZE: memory read address.
REQ-009 rptr  output  ADDRSIZE+1: registered Gray read pointer for the write-domain synchronizer.
REQ-010 rempty  output  1: registered empty flag; the memory holds no unread word.
REQ-011 dout  output  DATASIZE: first-word-fall-through output data.
REQ-012 dout_valid  output  1: dout holds a valid word.
REQ-013 dout_ready  input  1: consumer accepts dout this cycle.

Function
REQ-014 Internal binary pointer rbin (ADDRSIZE+1 bits); raddr = rbin[ADDRSIZE-1:0].
REQ-015 Internal pop rinc = !rempty && (!dout_valid || dout_ready); no other condition advances rbin.
REQ-016 rbinnext = rbin + rinc, modulo 2**(ADDRSIZE+1); rgraynext = (rbinnext>>1) ^ rbinnext.
REQ-017 Each edge: rbin <= rbinnext, rptr <= rgraynext, rempty <= (rgraynext == rq2_wptr).
REQ-018 On rinc, dout <= rdata (the word at the pre-increment raddr) and dout_valid <= 1.
REQ-019 dout_valid && dout_ready && !rinc: dout_valid <= 0 and dout holds its value.
REQ-020 Accept and pop in the same cycle: the next word loads and dout_valid stays 1 (no bubble).
REQ-021 dout_valid && !dout_ready: dout, dout_valid, and rbin all hold; dout never changes while stalled.
REQ-022 Latency: first edge with rempty=0 and the output empty -> dout_valid=1 after that edge.
REQ-023 Pointer wrap from 2**(ADDRSIZE+1)-1 to 0 is seamless; the MSB toggles once per lap.
REQ-024 Full-to-empty drain at one word per cycle: rempty asserts on the edge that consumes the last word; no underflow read.

Reset
REQ-025 rrst asserted: rbin=0, rptr=0, rempty=1, dout=0, and dout_valid=0 immediately, independent of rclk.
REQ-026 Reset mid-transfer discards dout and unread words; the first edge after deassertion evaluates REQ-017 normally.

Configuration
REQ-027 Macro FIFO_RD_LEVEL_EN defined: add output rlevel (ADDRSIZE+1 bits), registered, = gray2bin(rq2_wptr) - rbinnext, modulo 2**(ADDRSIZE+1); reset value 0.
REQ-028 rlevel counts only memory words and excludes the word held in dout.
REQ-029 Macro FIFO_RD_LEVEL_EN undefined: the rlevel port and its logic are absent; all other behaviour is identical.

Structure
REQ-030 Shared package fifo_pkg holds the default DATASIZE/ADDRSIZE constants and the bin2gray/gray2bin functions, also used by the write side.
REQ-031 One sub-module, fifo_gray2bin (parameter WIDTH), instantiated only under FIFO_RD_LEVEL_EN.

Verification
REQ-032 Reset: assert rrst with rq2_wptr=5'b00001 -> rempty=1, dout_valid=0, rptr=0 with no rclk edge.
REQ-033 Single word: mem[0]=8'hA5, rq2_wptr 0->1 (Gray) -> next edge rempty=0; following edge dout=8'hA5, dout_valid=1, rempty=1, rptr=5'b00001.
REQ-034 Stall: 3 words loaded, dout_ready=0 for 10 cycles -> dout constant, rbin advances exactly once, rlevel=2 if enabled.
REQ-035 Streaming: 16 words 0x00..0x0F, dout_ready=1 -> 16 consecutive valid beats in order, no bubble, rempty=1 after the last beat.
REQ-036 Wrap: 40 words streamed in bursts of 7 with random dout_ready -> data in order across two pointer laps; rptr equals the Gray of the word count mod 32.
REQ-037 Mid-burst reset: rrst pulse while dout_valid=1 -> dout_valid=0 immediately; after release, with rq2_wptr=0, rempty=1.

Source files
------------

// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared FIFO sizes and Gray-code helpers for both pointer domains
package fifo_pkg;

   localparam int FIFO_DATASIZE = 8;
   localparam int FIFO_ADDRSIZE = 4;
   localparam int GRAY_MAXW     = 32;

   // Callers zero-extend narrower pointers; leading zeros leave the low bits unchanged.
   function automatic logic [GRAY_MAXW-1:0] bin2gray(input logic [GRAY_MAXW-1:0] b);
      return b ^ (b >> 1);
   endfunction

   function automatic logic [GRAY_MAXW-1:0] gray2bin(input logic [GRAY_MAXW-1:0] g);
      logic [GRAY_MAXW-1:0] b;
      b[GRAY_MAXW-1] = g[GRAY_MAXW-1];
      for (int i = GRAY_MAXW-2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

endpackage

// File: rtl/fifo_rd_port_if.sv
// rtl/fifo_rd_port_if.sv - read-port signal bundle; rlevel exists only with FIFO_RD_LEVEL_EN
interface fifo_rd_port_if import fifo_pkg::*; #(
   parameter int DATASIZE = FIFO_DATASIZE,
   parameter int ADDRSIZE = FIFO_ADDRSIZE
) ();

   logic [ADDRSIZE:0]   rq2_wptr;
   logic [DATASIZE-1:0] rdata;
   logic [ADDRSIZE-1:0] raddr;
   logic [ADDRSIZE:0]   rptr;
   logic                rempty;
   logic [DATASIZE-1:0] dout;
   logic                dout_valid;
   logic                dout_ready;

`ifdef FIFO_RD_LEVEL_EN
   logic [ADDRSIZE:0]   rlevel;

   modport slave (
      input  rq2_wptr, rdata, dout_ready,
      output raddr, rptr, rempty, dout, dout_valid, rlevel
   );
   modport master (
      output rq2_wptr, rdata, dout_ready,
      input  raddr, rptr, rempty, dout, dout_valid, rlevel
   );
`else
   modport slave (
      input  rq2_wptr, rdata, dout_ready,
      output raddr, rptr, rempty, dout, dout_valid
   );
   modport master (
      output rq2_wptr, rdata, dout_ready,
      input  raddr, rptr, rempty, dout, dout_valid
   );
`endif

endinterface

// File: rtl/fifo_gray2bin.sv
// rtl/fifo_gray2bin.sv - combinational Gray-to-binary converter (WIDTH <= 32)
module fifo_gray2bin import fifo_pkg::*; #(
   parameter int WIDTH = FIFO_ADDRSIZE + 1
) (
   input  logic [WIDTH-1:0] gray,
   output logic [WIDTH-1:0] bin
);

   assign bin = WIDTH'(gray2bin(GRAY_MAXW'(gray)));

endmodule

// File: rtl/fifo_rd_port.sv
// rtl/fifo_rd_port.sv - async FIFO read side with first-word-fall-through output register
// Defining FIFO_RD_LEVEL_EN adds a registered fill level (rlevel) of unread memory words.
module fifo_rd_port import fifo_pkg::*; #(
   parameter int DATASIZE = FIFO_DATASIZE,
   parameter int ADDRSIZE = FIFO_ADDRSIZE
) (
   input  logic           rclk,
   input  logic           rrst,
   fifo_rd_port_if.slave  rd
);

   localparam int PW = ADDRSIZE + 1;

   logic [PW-1:0]       rbin;
   logic [PW-1:0]       rbinnext;
   logic [PW-1:0]       rgraynext;
   logic [PW-1:0]       rptr_q;
   logic                rempty_q;
   logic                rinc;
   logic [DATASIZE-1:0] dout_q;
   logic                dout_valid_q;

   // Pop from memory whenever the output register is free or being drained this cycle.
   always_comb begin
      rinc      = !rempty_q && (!dout_valid_q || rd.dout_ready);
      rbinnext  = rbin + PW'(rinc);
      rgraynext = PW'(bin2gray(GRAY_MAXW'(rbinnext)));
   end

   always_ff @(posedge rclk or posedge rrst) begin
      if (rrst) begin
         rbin         <= '0;
         rptr_q       <= '0;
         rempty_q     <= 1'b1;
         dout_q       <= '0;
         dout_valid_q <= 1'b0;
      end else begin
         rbin     <= rbinnext;
         rptr_q   <= rgraynext;
         rempty_q <= (rgraynext == rd.rq2_wptr);
         if (rinc) begin
            dout_q       <= rd.rdata;
            dout_valid_q <= 1'b1;
         end else if (rd.dout_ready) begin
            dout_valid_q <= 1'b0;
         end
      end
   end

   assign rd.raddr      = rbin[ADDRSIZE-1:0];
   assign rd.rptr       = rptr_q;
   assign rd.rempty     = rempty_q;
   assign rd.dout       = dout_q;
   assign rd.dout_valid = dout_valid_q;

`ifdef FIFO_RD_LEVEL_EN
   logic [PW-1:0] wbin;
   logic [PW-1:0] rlevel_q;

   fifo_gray2bin #(.WIDTH(PW)) u_wptr_g2b (
      .gray (rd.rq2_wptr),
      .bin  (wbin)
   );

   // Measured against the post-pop pointer, so the word sitting in dout is not counted.
   always_ff @(posedge rclk or posedge rrst) begin
      if (rrst) begin
         rlevel_q <= '0;
      end else begin
         rlevel_q <= wbin - rbinnext;
      end
   end

   assign rd.rlevel = rlevel_q;
`endif

endmodule

// File: tb/tb_fifo_rd_port.sv
// tb/tb_fifo_rd_port.sv - randomized scoreboard bench for fifo_rd_port (honours FIFO_RD_LEVEL_EN)
module tb_fifo_rd_port;

   logic rclk;
   logic rrst;
   logic [7:0] mem [16];

   fifo_rd_port_if #(.DATASIZE(8), .ADDRSIZE(4)) rd_if ();

   fifo_rd_port #(.DATASIZE(8), .ADDRSIZE(4)) dut (
      .rclk (rclk),
      .rrst (rrst),
      .rd   (rd_if)
   );

   assign rd_if.rdata = mem[rd_if.raddr];

   initial rclk = 1'b0;
   always #5 rclk = ~rclk;

   int n_checks = 0;
   int n_errors = 0;

   // Reference bookkeeping in word counts: written, visible at the last two edges, accepted.
   int wcount;
   int w_edge;
   int w_edge_prev;
   int accepted;
   int cyc;
   int first_acc_cyc;
   int last_acc_cyc;
   logic [7:0] exp_q [$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [4:0] gray5(input int n);
      logic [4:0] b;
      b = n[4:0];
      return b ^ (b >> 1);
   endfunction

   // One clock: check outputs after the edge against the count model, then drive the next inputs.
   task automatic step(input logic rdy, input logic wr, input logic [7:0] wd);
      logic exp_valid;
      int   popped;
      @(posedge rclk);
      w_edge_prev = w_edge;
      w_edge      = wcount;
      cyc++;
      #1;
      exp_valid = (w_edge_prev > accepted);
      popped    = accepted + (exp_valid ? 1 : 0);
      check("dout_valid", 32'(rd_if.dout_valid), 32'(exp_valid));
      check("rempty", 32'(rd_if.rempty), 32'(popped == w_edge));
      check("rptr", 32'(rd_if.rptr), 32'(gray5(popped)));
`ifdef FIFO_RD_LEVEL_EN
      check("rlevel", 32'(rd_if.rlevel), 32'((w_edge - popped) & 31));
`endif
      if (exp_valid && exp_q.size() > 0)
         check("dout", 32'(rd_if.dout), 32'(exp_q[0]));
      rd_if.dout_ready = rdy;
      if (exp_valid && rdy && exp_q.size() > 0) begin
         void'(exp_q.pop_front());
         accepted++;
         if (accepted == 1) first_acc_cyc = cyc;
         last_acc_cyc = cyc;
      end
      if (wr && (wcount - accepted) < 16) begin
         mem[wcount % 16] = wd;
         exp_q.push_back(wd);
         wcount++;
         rd_if.rq2_wptr = gray5(wcount);
      end
   endtask

   // Reset asserted between edges: outputs must clear before any clock edge arrives.
   task automatic do_reset(input logic [4:0] wp_during);
      #2;
      rd_if.rq2_wptr = wp_during;
      rrst = 1'b1;
      #1;
      check("reset_rempty", 32'(rd_if.rempty), 32'd1);
      check("reset_valid", 32'(rd_if.dout_valid), 32'd0);
      check("reset_rptr", 32'(rd_if.rptr), 32'd0);
      check("reset_dout", 32'(rd_if.dout), 32'd0);
`ifdef FIFO_RD_LEVEL_EN
      check("reset_rlevel", 32'(rd_if.rlevel), 32'd0);
`endif
      @(posedge rclk);
      #3;
      rrst = 1'b0;
      rd_if.rq2_wptr = 5'd0;
      rd_if.dout_ready = 1'b0;
      wcount = 0;
      w_edge = 0;
      w_edge_prev = 0;
      accepted = 0;
      exp_q.delete();
   endtask

   task automatic drain(input int max_cyc);
      int n;
      n = 0;
      while (accepted < wcount && n < max_cyc) begin
         step(1'b1, 1'b0, 8'h00);
         n++;
      end
      step(1'b1, 1'b0, 8'h00);
      check("drain_empty", 32'(rd_if.rempty), 32'd1);
      check("drain_valid", 32'(rd_if.dout_valid), 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int sent;
      int bpos;
      int gap;
      int wc0;
      logic rdy;
      logic wr;

      for (int i = 0; i < 16; i++) mem[i] = 8'h00;
      rrst = 1'b1;
      rd_if.rq2_wptr = 5'd0;
      rd_if.dout_ready = 1'b0;
      wcount = 0; w_edge = 0; w_edge_prev = 0; accepted = 0; cyc = 0;
      first_acc_cyc = 0; last_acc_cyc = 0;
      repeat (2) @(posedge rclk);
      #3;
      rrst = 1'b0;

      // Single word through an empty FIFO
      step(1'b0, 1'b1, 8'hA5);
      step(1'b0, 1'b0, 8'h00);
      check("single_rempty_low", 32'(rd_if.rempty), 32'd0);
      check("single_valid_low", 32'(rd_if.dout_valid), 32'd0);
      step(1'b0, 1'b0, 8'h00);
      check("single_dout", 32'(rd_if.dout), 32'hA5);
      check("single_valid", 32'(rd_if.dout_valid), 32'd1);
      check("single_rempty", 32'(rd_if.rempty), 32'd1);
      check("single_rptr", 32'(rd_if.rptr), 32'b00001);
      step(1'b1, 1'b0, 8'h00);
      step(1'b0, 1'b0, 8'h00);

      // Stall with three words queued
      step(1'b0, 1'b1, 8'hB0);
      step(1'b0, 1'b1, 8'hB1);
      step(1'b0, 1'b1, 8'hB2);
      repeat (10) step(1'b0, 1'b0, 8'h00);
      check("stall_dout", 32'(rd_if.dout), 32'hB0);
      check("stall_rptr", 32'(rd_if.rptr), 32'(gray5(2)));
`ifdef FIFO_RD_LEVEL_EN
      check("stall_rlevel", 32'(rd_if.rlevel), 32'd2);
`endif
      drain(40);

      // Asynchronous reset from a non-idle state, wptr nonzero during reset
      step(1'b0, 1'b1, 8'hC3);
      repeat (3) step(1'b0, 1'b0, 8'h00);
      do_reset(5'b00001);

      // Streaming 16 words with the consumer always ready
      for (int i = 0; i < 16; i++) step(1'b1, 1'b1, 8'(i));
      drain(40);
      check("stream_count", 32'(accepted), 32'd16);
      check("stream_no_bubble", 32'(last_acc_cyc - first_acc_cyc), 32'd15);

      // Two pointer laps: bursts of 7 writes, random consumer
      do_reset(5'b00000);
      sent = 0; bpos = 0; gap = 0;
      for (int c = 0; c < 3000 && !(sent == 40 && accepted == 40); c++) begin
         rdy = ($urandom_range(0, 3) != 0);
         wr  = (sent < 40 && gap == 0);
         wc0 = wcount;
         step(rdy, wr, 8'(sent * 3 + 1));
         if (wcount != wc0) begin
            sent++;
            bpos++;
            if (bpos == 7) begin
               bpos = 0;
               gap = $urandom_range(1, 4);
            end
         end else if (gap > 0) begin
            gap--;
         end
      end
      check("wrap_count", 32'(accepted), 32'd40);
      repeat (2) step(1'b1, 1'b0, 8'h00);
      check("wrap_rptr", 32'(rd_if.rptr), 32'b01100);
      check("wrap_rempty", 32'(rd_if.rempty), 32'd1);

      // Reset while a word is held in dout
      step(1'b0, 1'b1, 8'h5A);
      step(1'b0, 1'b1, 8'h6B);
      repeat (2) step(1'b0, 1'b0, 8'h00);
      check("midrst_valid_before", 32'(rd_if.dout_valid), 32'd1);
      do_reset(5'b00000);
      repeat (2) step(1'b0, 1'b0, 8'h00);
      check("midrst_rempty", 32'(rd_if.rempty), 32'd1);
      check("midrst_valid", 32'(rd_if.dout_valid), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
